rr_mux_reg: RTL and testbench
=============================

// Module: rr_mux_reg
// PURPOSE
//  Registered, handshaked N:1 multiplexer with built-in arbitration. Each cycle it selects one
//  valid input channel by fixed-priority or round-robin policy and loads it into a one-entry
//  output register. Sits between multiple producers and one shared consumer/bus.
//  Differs from a combinational mux: it adds valid/ready flow control, arbitration state and
//  a registered output.
// PARAMETERS
//  CHANNELS   2  number of input channels (>=1)
//  WIDTH      1  data width per channel, bits
//  RR_MODE    1  1 = round-robin arbitration, 0 = fixed priority (channel 0 highest)
//  ADDR_SIZE  derived: (CHANNELS>1) ? $clog2(CHANNELS) : 1; not overridden
// PORTS
//  clk        in   1                 single clock, all state on rising edge
//  rst        in   1                 synchronous, active-high reset
//  in_data    in   WIDTH*CHANNELS    channel i occupies [WIDTH*i +: WIDTH]
//  in_valid   in   CHANNELS          per-channel valid
//  in_ready   out  CHANNELS          per-channel ready; one-hot or zero
//  enable     in   1                 0 = block new grants; a held output still drains
//  out_data   out  WIDTH             registered data
//  out_sel    out  ADDR_SIZE         channel index of the held out_data
//  out_valid  out  1                 output register holds a word
//  out_ready  in   1                 consumer accepts when out_valid & out_ready
// BEHAVIOUR
//  - Reset (rst=1 at an edge): out_valid=0, out_data=0, out_sel=0, rr_ptr=0.
//    in_ready is combinational and is 0 while rst=1. Any in-flight word is discarded.
//  - load = enable & |(in_valid) & (~out_valid | out_ready). Bubble-free: a word can be
//    drained and a new one loaded in the same cycle.
//  - grant (one-hot) = arbitration over in_valid & {CHANNELS{enable}}.
//    in_ready = load ? grant : 0. A transfer happens on channel i when in_valid[i] & in_ready[i].
//  - RR_MODE=1: search starts at rr_ptr and wraps at CHANNELS-1 -> 0.
//    On load with grant index k: rr_ptr <= (k==CHANNELS-1) ? 0 : k+1.
//    rr_ptr does not change without a load.
//  - RR_MODE=0: lowest-index valid channel wins; rr_ptr is unused and stays 0.
//  - Latency: an input accepted at edge T appears with out_valid=1 after T.
//    Throughput is 1 word/cycle.
//  - On load edge: out_data <= selected word, out_sel <= k, out_valid <= 1.
//  - Drain without load: out_valid <= 0. out_data and out_sel hold their last values.
//  - Stall (out_valid & ~out_ready): out_data, out_sel and out_valid are held stable.
//    in_ready = 0.
//  - No valid inputs or enable=0: no load, rr_ptr holds. in_ready=0.
//  - CHANNELS=1: grant = in_valid[0]; out_sel is constant 0.
//  - in_valid may drop without a transfer; the arbiter never holds a grant across cycles.
// STRUCTURE
//  - Shared package mux_pkg: function sel_width(CHANNELS) for ADDR_SIZE; ADDR_SIZE is
//    computed from it. Also a typedef for arbitration mode constants RR_FIXED=0, RR_ROUND=1.
//  - Sub-module rr_arbiter #(CHANNELS, RR_MODE): combinational request/pointer -> one-hot
//    grant plus index.
//  - Data select: AND-OR of in_data slices with grant bits, the same scheme as the existing
//    Mux. Top level holds the rr_ptr and output registers.
// TESTING
//  1. Reset: rst=1 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0.
//  2. RR fairness: CHANNELS=4, WIDTH=8, RR_MODE=1, all valid, out_ready=1, data i=8'hA0+i
//     -> out_sel sequence 0,1,2,3,0; one word per cycle.
//  3. Fixed priority: RR_MODE=0, in_valid=4'b1010 -> out_sel=1 every cycle; channel 3 is
//     starved.
//  4. Backpressure: out_ready=0 for 3 cycles after a load of 8'hA2 -> out_data and out_sel
//     stable, in_ready=0. Raise out_ready -> drain plus new load on the same edge.
//  5. Wrap and sparse: rr_ptr=3, in_valid=4'b0101 -> grant channel 0 (wrap), then channel 2.
//  6. enable=0 with valid inputs and a held word, out_ready=1 -> word drains, out_valid=0,
//     no in_ready, rr_ptr unchanged. Mid-stream rst -> state matches scenario 1 next cycle.

Source files
------------

// File: rtl/rr_mux_reg_pkg.sv
// Shared definitions for the arbitrated registered mux: select-width helper and arbitration modes.
package mux_pkg;

  typedef enum logic {
    RR_FIXED = 1'b0,
    RR_ROUND = 1'b1
  } rr_mode_e;

  // A single channel still needs one bit so index ports never collapse to zero width.
  function automatic int sel_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/rr_mux_reg_if.sv
// Producer/consumer bundle for rr_mux_reg: per-channel valid/ready inputs, one registered output.
interface rr_mux_reg_if
  import mux_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 1
);
  localparam int ADDR_SIZE = sel_width(CHANNELS);

  logic [WIDTH*CHANNELS-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic                      enable;
  logic [WIDTH-1:0]          out_data;
  logic [ADDR_SIZE-1:0]      out_sel;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output in_data, in_valid, enable, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  modport slave (
    input  in_data, in_valid, enable, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );

endinterface

// File: rtl/rr_mux_reg_arbiter.sv
// Combinational arbiter: request vector plus search pointer -> one-hot grant and its index.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int RR_MODE  = 1
) (
  input  logic [CHANNELS-1:0]            req,
  input  logic [sel_width(CHANNELS)-1:0] ptr,
  output logic [CHANNELS-1:0]            grant,
  output logic [sel_width(CHANNELS)-1:0] idx
);
  localparam int          ADDR_SIZE = sel_width(CHANNELS);
  localparam int unsigned NCH       = CHANNELS;

  int unsigned cand;
  logic        found;

  // Walk channels in priority order; round-robin starts at ptr and wraps, fixed starts at 0.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (RR_MODE == int'(RR_ROUND)) begin
        cand = (32'(ptr) + i) % NCH;
      end else begin
        cand = i;
      end
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = ADDR_SIZE'(cand);
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux_reg.sv
// Registered N:1 mux with valid/ready flow control and fixed-priority or round-robin arbitration.
module rr_mux_reg
  import mux_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 1,
  parameter int RR_MODE  = 1
) (
  input  logic         clk,
  input  logic         rst,
  rr_mux_reg_if.slave  bus
);
  localparam int ADDR_SIZE = sel_width(CHANNELS);

  logic [CHANNELS-1:0]  req;
  logic [CHANNELS-1:0]  grant;
  logic [ADDR_SIZE-1:0] grant_idx;
  logic [ADDR_SIZE-1:0] rr_ptr;
  logic [WIDTH-1:0]     sel_data;
  logic                 load;

  logic [WIDTH-1:0]     out_data_q;
  logic [ADDR_SIZE-1:0] out_sel_q;
  logic                 out_valid_q;

  assign req  = bus.in_valid & {CHANNELS{bus.enable}};
  assign load = bus.enable & (|bus.in_valid) & (~out_valid_q | bus.out_ready);

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .RR_MODE  (RR_MODE)
  ) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx)
  );

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      sel_data = sel_data | (bus.in_data[WIDTH*i +: WIDTH] & {WIDTH{grant[i]}});
    end
  end

  assign bus.in_ready  = (load && !rst) ? grant : '0;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      rr_ptr      <= '0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sel_data;
      out_sel_q   <= grant_idx;
      if (RR_MODE == int'(RR_ROUND)) begin
        rr_ptr <= (grant_idx == ADDR_SIZE'(CHANNELS - 1)) ? '0 : grant_idx + ADDR_SIZE'(1);
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_reg.sv
// Drives a round-robin and a fixed-priority rr_mux_reg with shared stimulus against a queue-free reference model.
module tb_rr_mux_reg;
  localparam int CH = 4;
  localparam int W  = 8;

  logic clk = 1'b0;
  logic rst;
  logic [W*CH-1:0] in_data;
  logic [CH-1:0]   in_valid;
  logic            enable;
  logic            out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state, index 0 = fixed priority DUT, 1 = round-robin DUT
  bit       m_valid [2];
  int       m_data  [2];
  int       m_sel   [2];
  int       m_ptr   [2];

  rr_mux_reg_if #(.CHANNELS(CH), .WIDTH(W)) bus_fx ();
  rr_mux_reg_if #(.CHANNELS(CH), .WIDTH(W)) bus_rr ();

  assign bus_fx.in_data   = in_data;
  assign bus_fx.in_valid  = in_valid;
  assign bus_fx.enable    = enable;
  assign bus_fx.out_ready = out_ready;
  assign bus_rr.in_data   = in_data;
  assign bus_rr.in_valid  = in_valid;
  assign bus_rr.enable    = enable;
  assign bus_rr.out_ready = out_ready;

  rr_mux_reg #(.CHANNELS(CH), .WIDTH(W), .RR_MODE(0)) dut_fx (
    .clk (clk), .rst (rst), .bus (bus_fx.slave)
  );
  rr_mux_reg #(.CHANNELS(CH), .WIDTH(W), .RR_MODE(1)) dut_rr (
    .clk (clk), .rst (rst), .bus (bus_rr.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // First requesting channel in search order, or -1 when nothing requests.
  function automatic int pick(input int mode, input logic [CH-1:0] req, input int ptr);
    int start;
    start = (mode == 1) ? ptr : 0;
    for (int off = 0; off < CH; off++) begin
      if (req[(start + off) % CH]) return (start + off) % CH;
    end
    return -1;
  endfunction

  function automatic logic [31:0] dut_ready(input int m);
    return (m == 1) ? 32'(bus_rr.in_ready) : 32'(bus_fx.in_ready);
  endfunction
  function automatic logic [31:0] dut_valid(input int m);
    return (m == 1) ? 32'(bus_rr.out_valid) : 32'(bus_fx.out_valid);
  endfunction
  function automatic logic [31:0] dut_data(input int m);
    return (m == 1) ? 32'(bus_rr.out_data) : 32'(bus_fx.out_data);
  endfunction
  function automatic logic [31:0] dut_sel(input int m);
    return (m == 1) ? 32'(bus_rr.out_sel) : 32'(bus_fx.out_sel);
  endfunction

  // One clock: check combinational ready, advance the model on the edge, check the registers.
  task automatic step();
    int g [2];
    bit ld [2];
    #1;
    for (int m = 0; m < 2; m++) begin
      g[m]  = enable ? pick(m, in_valid, m_ptr[m]) : -1;
      ld[m] = enable && (in_valid != 0) && (!m_valid[m] || out_ready);
      check(m ? "rr_in_ready" : "fx_in_ready", dut_ready(m),
            (ld[m] && !rst && g[m] >= 0) ? (32'd1 << g[m]) : 32'd0);
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_valid[m] = 0; m_data[m] = 0; m_sel[m] = 0; m_ptr[m] = 0;
      end else if (ld[m]) begin
        m_valid[m] = 1;
        m_data[m]  = int'(in_data[g[m]*W +: W]);
        m_sel[m]   = g[m];
        if (m == 1) m_ptr[m] = (g[m] + 1) % CH;
      end else if (out_ready) begin
        m_valid[m] = 0;
      end
    end
    #1;
    for (int m = 0; m < 2; m++) begin
      check(m ? "rr_out_valid" : "fx_out_valid", dut_valid(m), 32'(m_valid[m]));
      check(m ? "rr_out_data"  : "fx_out_data",  dut_data(m),  32'(m_data[m]));
      check(m ? "rr_out_sel"   : "fx_out_sel",   dut_sel(m),   32'(m_sel[m]));
    end
    @(negedge clk);
  endtask

  initial begin
    int exp_seq [5];
    exp_seq = '{0, 1, 2, 3, 0};
    for (int m = 0; m < 2; m++) begin
      m_valid[m] = 0; m_data[m] = 0; m_sel[m] = 0; m_ptr[m] = 0;
    end
    rst = 1'b1; enable = 1'b1; out_ready = 1'b1; in_valid = '1;
    for (int i = 0; i < CH; i++) in_data[i*W +: W] = 8'hA0 + 8'(i);
    @(negedge clk);

    // Reset with every channel requesting
    repeat (2) step();
    check("rst_valid", dut_valid(1), 32'd0);
    check("rst_data",  dut_data(1),  32'd0);
    rst = 1'b0;

    // Round-robin fairness, one word per cycle
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_seq_sel",  dut_sel(1),  32'(exp_seq[i]));
      check("rr_seq_data", dut_data(1), 32'(8'hA0 + exp_seq[i]));
      check("fx_seq_sel",  dut_sel(0),  32'd0);
    end

    // Fixed priority starves channel 3
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      check("fx_prio_sel", dut_sel(0), 32'd1);
    end

    // Backpressure holding A2, then drain and reload on one edge
    in_valid = 4'b0100;
    step();
    out_ready = 1'b0; in_valid = '1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_data", dut_data(1), 32'h0A2);
      check("stall_sel",  dut_sel(1),  32'd2);
    end
    out_ready = 1'b1;
    step();
    check("unstall_data", dut_data(1), 32'h0A3);
    check("unstall_vld",  dut_valid(1), 32'd1);

    // Wrap from pointer 3 over a sparse request set
    in_valid = 4'b0100;
    step();
    in_valid = 4'b0101;
    step();
    check("wrap_sel0", dut_sel(1), 32'd0);
    step();
    check("wrap_sel2", dut_sel(1), 32'd2);

    // enable=0 drains the held word and leaves the pointer alone
    in_valid = '1; enable = 1'b0;
    step();
    check("dis_valid", dut_valid(1), 32'd0);
    step();
    enable = 1'b1;
    step();
    check("dis_ptr_sel", dut_sel(1), 32'd3);
    rst = 1'b1;
    step();
    check("mid_rst_valid", dut_valid(1), 32'd0);
    check("mid_rst_sel",   dut_sel(1),   32'd0);
    rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = CH'($urandom);
      in_data   = (W*CH)'($urandom);
      enable    = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
